// File: rtl/rs255_pkg.sv
// rs255_pkg: shared constants, symbol type, GF(2^8) multiply and the RS(255,239)
// generator coefficients g0..g15 (derived at elaboration from roots alpha^0..alpha^15).
package rs255_pkg;
   localparam int N = 255;
   localparam int K = 239;
   localparam int NPAR = N - K;
   localparam logic [8:0] PRIM_POLY = 9'h11D;
   typedef logic [7:0] sym_t;
   typedef sym_t [NPAR-1:0] coef_t;
   typedef sym_t [NPAR:0] poly_t;
   function automatic sym_t gmul(input sym_t a, input sym_t b);
      sym_t p;
      sym_t x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
      end
      return p;
   endfunction
   // Multiply out (x + alpha^i) for i = 0..15; the monic x^16 term is dropped.
   function automatic coef_t gen_coefs();
      poly_t c;
      poly_t nc;
      sym_t r;
      c = '0;
      c[0] = 8'h01;
      r = 8'h01;
      for (int i = 0; i < NPAR; i++) begin
         nc = '0;
         for (int j = 0; j <= NPAR; j++) begin
            if (j > 0) nc[j] = c[j-1];
            nc[j] ^= gmul(c[j], r);
         end
         c = nc;
         r = gmul(r, 8'h02);
      end
      return c[NPAR-1:0];
   endfunction
   localparam coef_t G = gen_coefs();
endpackage

// File: rtl/rs255_encoder_cmul.sv
// gf256_cmul: multiply a GF(2^8) symbol by the constant C; the columns fold to
// constants, leaving a pure XOR network.
module gf256_cmul
   import rs255_pkg::*;
#(
   parameter sym_t C = 8'h01
) (
   input  logic [7:0] a,
   output logic [7:0] y
);
   always_comb begin
      y = '0;
      for (int i = 0; i < 8; i++) y ^= {8{a[i]}} & gmul(C, sym_t'(1 << i));
   end
endmodule

// File: rtl/rs255_encoder.sv
// rs255_encoder: systematic RS(255,239) encoder, one symbol per enabled clock.
// RS_ENC_OUT_PIPE_EN adds one en-gated output register stage (latency 2).
module rs255_encoder
   import rs255_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       encode_start,
   input  logic [7:0] msg,
   output logic [7:0] r_code_out,
   output logic       finish
);
   logic [7:0] cnt_q, cnt_d;
   coef_t p_q, p_d, prod;
   sym_t code_q, code_d, fb;
   logic fin_q, fin_d, par;
   for (genvar i = 0; i < NPAR; i++) begin : g_mul
      gf256_cmul #(.C(G[i])) u_mul (.a(fb), .y(prod[i]));
   end
   // After 16 parity shifts p is all zero again, so the wrap to cnt=0 needs no clear.
   always_comb begin
      par = (cnt_q >= 8'(K)) && !encode_start;
      fb = encode_start ? msg : msg ^ p_q[NPAR-1];
      cnt_d = cnt_q;
      p_d = p_q;
      code_d = code_q;
      fin_d = 1'b0;
      if (en) begin
         if (par) begin
            code_d = p_q[NPAR-1];
            p_d = {p_q[NPAR-2:0], 8'h00};
            fin_d = cnt_q == 8'(N-1);
            cnt_d = fin_d ? '0 : cnt_q + 8'd1;
         end else begin
            code_d = msg;
            p_d = (encode_start ? '0 : {p_q[NPAR-2:0], 8'h00}) ^ prod;
            cnt_d = encode_start ? 8'd1 : cnt_q + 8'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         p_q <= '0;
         code_q <= '0;
         fin_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         p_q <= p_d;
         code_q <= code_d;
         fin_q <= fin_d;
      end
   end
`ifdef RS_ENC_OUT_PIPE_EN
   sym_t code2_q, code2_d;
   logic fin2_q, fin2_d;
   always_comb begin
      code2_d = en ? code_q : code2_q;
      fin2_d = en ? fin_q : 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code2_q <= '0;
         fin2_q <= 1'b0;
      end else begin
         code2_q <= code2_d;
         fin2_q <= fin2_d;
      end
   end
   assign r_code_out = code2_q;
   assign finish = fin2_q;
`else
   assign r_code_out = code_q;
   assign finish = fin_q;
`endif
endmodule

// File: tb/tb_rs255_encoder.sv
// tb_rs255_encoder: scoreboard bench; expected codewords come from log/antilog GF
// arithmetic and textbook polynomial division, DUT codewords are also syndrome-checked.
module tb_rs255_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic encode_start = 1'b0;
   logic [7:0] msg = 8'h00;
   logic [7:0] r_code_out;
   logic finish;
   always #5 clk = ~clk;
   rs255_encoder dut (
      .clk(clk), .rst_n(rst_n), .en(en), .encode_start(encode_start),
      .msg(msg), .r_code_out(r_code_out), .finish(finish)
   );
   typedef struct {
      logic [7:0] code;
      bit fin;
      int idx;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int errors = 0;
   int checks = 0;
   int alog[256];
   int lg[256];
   int gb[17];
   logic [7:0] msg_buf[239];
   int cw[255];
   int cap[255];
   logic [7:0] last_code = 8'h00;
   bit en_s = 1'b0;
   function automatic int mul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return alog[(lg[a] + lg[b]) % 255];
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask
   task automatic init_field();
      int x;
      x = 1;
      for (int i = 0; i < 255; i++) begin
         alog[i] = x;
         lg[x] = i;
         x = x << 1;
         if ((x & 256) != 0) x = x ^ 285;
      end
      for (int j = 0; j < 17; j++) gb[j] = 0;
      gb[0] = 1;
      for (int i = 0; i < 16; i++)
         for (int j = 16; j >= 0; j--) begin
            int lo;
            lo = 0;
            if (j > 0) lo = gb[j-1];
            gb[j] = lo ^ mul(gb[j], alog[i]);
         end
   endtask
   // Codeword = m(x)*x^16 + (m(x)*x^16 mod g(x)); symbol 0 is the x^254 coefficient.
   task automatic build_cw();
      int d[255];
      int c;
      for (int k = 0; k < 255; k++) d[k] = 0;
      for (int k = 0; k < 239; k++) d[254-k] = int'(msg_buf[k]);
      for (int deg = 254; deg >= 16; deg--) begin
         c = d[deg];
         if (c != 0)
            for (int j = 0; j <= 16; j++) d[deg-16+j] = d[deg-16+j] ^ mul(c, gb[j]);
      end
      for (int k = 0; k < 239; k++) cw[k] = int'(msg_buf[k]);
      for (int i = 0; i < 16; i++) cw[239+i] = d[15-i];
   endtask
   task automatic cyc(input bit ev, input bit sv, input logic [7:0] mv, input int idx);
      en = ev;
      encode_start = sv;
      msg = mv;
      if (ev) q.push_back('{8'(cw[idx]), idx == 254, idx});
      @(posedge clk);
      #2;
   endtask
   task automatic run_frame(input bit st, input int len, input int sa, input int sb, input int sl);
      build_cw();
      for (int k = 0; k < len; k++) begin
         if (k == sa || k == sb)
            for (int s = 0; s < sl; s++) cyc(1'b0, 1'b1, 8'($urandom), 0);
         cyc(1'b1, st && k == 0, (k < 239) ? msg_buf[k] : 8'($urandom), k);
      end
   endtask
   task automatic fill_rand();
      for (int k = 0; k < 239; k++) msg_buf[k] = 8'($urandom);
   endtask
   initial forever begin
      @(posedge clk);
      en_s = en && rst_n;
   end
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("reset_code", 32'(r_code_out), 32'h0);
         chk("reset_finish", 32'(finish), 32'h0);
         last_code = 8'h00;
      end else if (en_s) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow: got output %0h with no expected symbol", r_code_out);
         end else begin
            e = q.pop_front();
            chk($sformatf("sym%0d", e.idx), 32'(r_code_out), 32'(e.code));
            chk($sformatf("finish%0d", e.idx), 32'(finish), 32'(e.fin));
            cap[e.idx] = int'(r_code_out);
            last_code = e.code;
            if (e.idx == 254)
               for (int j = 0; j < 16; j++) begin
                  int s;
                  s = 0;
                  for (int k = 0; k < 255; k++) s = mul(s, alog[j]) ^ cap[k];
                  chk($sformatf("syndrome%0d", j), 32'(s), 32'h0);
               end
         end
      end else begin
         chk("hold_code", 32'(r_code_out), 32'(last_code));
         chk("hold_finish", 32'(finish), 32'h0);
      end
   end
   initial begin
      init_field();
      en = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 239; k++) msg_buf[k] = 8'h00;
      run_frame(1'b1, 255, -1, -1, 0);
      msg_buf[238] = 8'h01;
      run_frame(1'b1, 255, -1, -1, 0);
      for (int k = 0; k < 239; k++) msg_buf[k] = 8'(k + 1);
      run_frame(1'b1, 255, -1, -1, 0);
      fill_rand();
      run_frame(1'b1, 255, -1, -1, 0);
      fill_rand();
      run_frame(1'b0, 255, -1, -1, 0);
      fill_rand();
      run_frame(1'b1, 255, 10, 245, 5);
      fill_rand();
      run_frame(1'b1, 100, -1, -1, 0);
      #4;
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      rst_n = 1'b1;
      fill_rand();
      run_frame(1'b0, 255, -1, -1, 0);
      fill_rand();
      run_frame(1'b1, 50, -1, -1, 0);
      fill_rand();
      run_frame(1'b1, 255, -1, -1, 0);
      repeat (4) begin
         fill_rand();
         run_frame(1'($urandom), 255, $urandom_range(0, 254), $urandom_range(0, 254),
                   $urandom_range(1, 3));
      end
      en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("queue_empty", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rs255_encoder.md
# rs255_encoder

Systematic Reed-Solomon RS(255,239) encoder over GF(2^8), one 8-bit symbol per clock. It sits in the transmit datapath ahead of the framer/modulator. Each frame takes 239 message symbols and emits a 255-symbol codeword: the 239 message symbols unchanged, then 16 parity symbols. It corrects up to 8 symbol errors downstream.

## Interface
Parameters
- N, 255: codeword length in symbols (fixed; not for override).
- K, 239: message length in symbols (fixed; 2T = N-K = 16).

Ports
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  clock enable; all state advances only when high.
- encode_start  in  1  frame start; sampled when en=1; the current msg is message symbol 0.
- msg  in  8  message symbol input; ignored during the parity phase.
- r_code_out  out  8  registered codeword symbol output.
- finish  out  1  one-cycle pulse with the last parity symbol (codeword symbol 254).

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Generator: g(x) = prod_{i=0..15} (x - alpha^i) = x^16 + g15 x^15 + … + g0.
- Symbol counter cnt, range 0..254:
  - Message phase: cnt 0..238.
  - Parity phase: cnt 239..254.
- Message phase (en=1):
  - fb = msg ^ p[15].
  - p[i] <= p[i-1] ^ gmul(g_i, fb) for i=1..15; p[0] <= gmul(g0, fb).
  - r_code_out <= msg.
- Parity phase (en=1):
  - r_code_out <= p[15].
  - Shift p[i] <= p[i-1], p[0] <= 0; msg is ignored.
- Constant multipliers are pure XOR networks; there are no table RAMs.
- encode_start=1 with en=1 (any cnt, including mid-frame):
  - Aborts the current frame and clears p to 0 before using it.
  - Processes msg as symbol 0 with fb = msg; the next cnt is 1.
- After cnt=254 the counter wraps to 0 and p clears, so the next frame streams back-to-back without a new encode_start.
- en=0: cnt, p and r_code_out hold; finish <= 0; encode_start is ignored.

## Timing
- Reset values: r_code_out=0, finish=0, cnt=0, p=0.
- Latency: the codeword symbol for cnt=k appears on r_code_out after the rising edge that consumes cnt=k (1 cycle).
- finish is 1 for exactly the cycle in which r_code_out holds symbol 254, and 0 otherwise.
- Throughput: 1 symbol per enabled clock; 255 enabled clocks per codeword.
- rst_n asserted mid-frame: the frame is abandoned immediately. After release, the first enabled edge treats msg as symbol 0, even without encode_start.

## Configuration
- RS_ENC_OUT_PIPE_EN defined: one extra output register stage on both r_code_out and finish.
  - Latency becomes 2 cycles.
  - The stage is gated by en and reset to 0.
- RS_ENC_OUT_PIPE_EN undefined: 1-cycle latency as specified above.

## Structure
- Package rs255_pkg holds:
  - N, K, NPAR=16.
  - The primitive polynomial constant.
  - The typedef for an 8-bit symbol.
  - The generator coefficient array g[0..15], computed by a constant function from the roots alpha^0..alpha^15.
  - The gmul function.
- One sub-module, gf256_cmul: an 8-bit constant-coefficient GF multiplier, instantiated 16 times in the LFSR.

## Test plan
- All-zero message (239 zeros) after encode_start -> 255 zero outputs; finish pulses once, on symbol 254.
- Symbol 238 = 0x01, all others 0 -> parity symbols 239..254 equal g15, g14, …, g0 in that order.
- Random message, e.g. 1,2,…,239 -> output symbols 0..238 equal the input. All 16 syndromes S_j = C(alpha^j), j=0..15, are 0.
- Two back-to-back frames with encode_start only on the first -> both codewords are correct; finish pulses at cycles 254 and 509.
- en low for 5 cycles at cnt=10, then for 5 cycles during parity -> outputs hold while en is low. The codeword is identical to the no-stall run.
- rst_n low at cnt=100, and encode_start at cnt=50 of a frame -> after rst_n low, outputs are 0. After encode_start, a fresh correct codeword starts from that msg.
